div_fix_point: RTL and testbench

Iterative signed fixed-point divider for the datapath's Q-format arithmetic, computing `in_1 / in_2` for the same N-bit, Q-fraction-bit format the multiplier produces and consumes. It is a radix-2 restoring divider that produces one quotient bit per clock under a start/done handshake, with fixed latency. Results are saturated and flagged on overflow or divide-by-zero. It is the inverse operation of `mult_fix_point` and sits beside it in the arithmetic unit.

---
 rtl/div_fix_point_if.sv | 30 +++
 rtl/div_fix_point.sv | 175 +++++++++++++++++
 tb/tb_div_fix_point.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_fix_point_if.sv
// Request/result bundle for the iterative fixed-point divider.
//
// Handshake: the master raises start with in_1/in_2 valid; the divider
// accepts on the first rising edge where it is idle (busy=0) and start=1,
// capturing both operands on that edge. busy then stays high until the
// result edge. done pulses for exactly one cycle, and out/div_by_zero/overflow
// are valid from that cycle and hold until the next done. start seen while
// busy=1 is ignored; there is no back-pressure on the result side.
interface div_fix_point_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] in_1;
    logic [N-1:0] in_2;
    logic         busy;
    logic         done;
    logic [N-1:0] out;
    logic         div_by_zero;
    logic         overflow;

    modport master (
        output start, in_1, in_2,
        input  busy, done, out, div_by_zero, overflow
    );

    modport slave (
        input  start, in_1, in_2,
        output busy, done, out, div_by_zero, overflow
    );
endinterface

// File: rtl/div_fix_point.sv
// Signed Q-format divider: radix-2 restoring division of |in_1|<<Q by |in_2|,
// one quotient bit per clock, fixed latency of N+Q cycles from the accepting
// edge to the registered result. Saturates and flags on overflow / zero divisor.
module div_fix_point #(
    parameter int Q = 12,
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    div_fix_point_if.slave  bus,
    output logic [1:0]      dbg_state
);

    // Quotient magnitude width and iteration count.
    localparam int QW    = N - 1 + Q;
    localparam int ITERS = N + Q - 1;
    localparam int CW    = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Control strobes decoded from the current state.
    logic busy_c;
    logic load;
    logic step;
    logic finish;

    // Datapath registers.
    logic [CW-1:0] cnt_q;
    logic          sign_q;
    logic [N-2:0]  dvs_q;     // divisor magnitude
    logic [N-1:0]  rem_q;     // partial remainder
    logic [QW-1:0] shq_q;     // numerator shifts out of the top, quotient bits shift in at the bottom

    // Registered results.
    logic [N-1:0]  out_q;
    logic          done_q;
    logic          dz_q;
    logic          ov_q;

    // Combinational helpers.
    logic [N-2:0]  mag_1;
    logic [N-2:0]  mag_2;
    logic [N:0]    rem_shift;
    logic          q_bit;
    logic [N-1:0]  rem_next;
    logic          res_ovf;
    logic [N-2:0]  res_mag;
    logic [N-1:0]  sat_val;
    logic [N-1:0]  res_val;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CALC on start, CALC for ITERS cycles, one FIN cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST_CNT) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/strobe decode: busy covers CALC and FIN so it drops on the result edge.
    always_comb begin
        busy_c = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state_q)
            S_IDLE: load = bus.start;
            S_CALC: begin
                busy_c = 1'b1;
                step   = 1'b1;
            end
            S_FIN: begin
                busy_c = 1'b1;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand magnitudes: low N-1 bits of the negation, so the most negative
    // code maps to magnitude 0 just as in the multiplier.
    always_comb begin
        mag_1 = bus.in_1[N-1] ? (~bus.in_1[N-2:0] + (N-1)'(1)) : bus.in_1[N-2:0];
        mag_2 = bus.in_2[N-1] ? (~bus.in_2[N-2:0] + (N-1)'(1)) : bus.in_2[N-2:0];
    end

    // One restoring step: shift the next numerator bit in, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, shq_q[QW-1]};
        q_bit     = (rem_shift >= {2'b00, dvs_q});
        rem_next  = q_bit ? N'(rem_shift - {2'b00, dvs_q}) : rem_shift[N-1:0];
    end

    // Result selection: zero divisor wins over overflow; zero magnitude stays 0.
    always_comb begin
        res_ovf = |shq_q[QW-1:N-1];
        res_mag = shq_q[N-2:0];
        sat_val = sign_q ? {1'b1, {(N-2){1'b0}}, 1'b1} : {1'b0, {(N-1){1'b1}}};
        res_val = sign_q ? (~{1'b0, res_mag} + N'(1)) : {1'b0, res_mag};
    end

    // Datapath: capture on accept, iterate in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sign_q <= 1'b0;
            dvs_q  <= '0;
            rem_q  <= '0;
            shq_q  <= '0;
        end else if (load) begin
            cnt_q  <= '0;
            sign_q <= bus.in_1[N-1] ^ bus.in_2[N-1];
            dvs_q  <= mag_2;
            rem_q  <= '0;
            shq_q  <= {mag_1, {Q{1'b0}}};
        end else if (step) begin
            cnt_q  <= cnt_q + CW'(1);
            rem_q  <= rem_next;
            shq_q  <= {shq_q[QW-2:0], q_bit};
        end
    end

    // Result registers: updated only in FIN, held otherwise; done is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                if (dvs_q == '0) begin
                    out_q <= sat_val;
                    dz_q  <= 1'b1;
                    ov_q  <= 1'b0;
                end else if (res_ovf) begin
                    out_q <= sat_val;
                    dz_q  <= 1'b0;
                    ov_q  <= 1'b1;
                end else begin
                    out_q <= res_val;
                    dz_q  <= 1'b0;
                    ov_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_q;
    assign bus.out         = out_q;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_div_fix_point.sv
// Bench for div_fix_point: directed vectors with literal expectations, a
// transaction-level reference model checked every cycle, handshake, reset
// and randomised operand checks.
module tb_div_fix_point;

    localparam int N = 32;
    localparam int Q = 12;
    localparam int LAT = N + Q;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    div_fix_point_if #(.N(N)) bus ();

    div_fix_point #(.Q(Q), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic longint unsigned mag31(input logic [31:0] x);
        logic [31:0] t;
        t = x[31] ? (32'd0 - x) : x;
        return {33'd0, t[30:0]};
    endfunction

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] o, output logic dz, output logic ov);
        longint unsigned ma, mb, qv;
        logic neg;
        logic [31:0] sat;
        neg = a[31] ^ b[31];
        ma  = mag31(a);
        mb  = mag31(b);
        sat = neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
        if (mb == 0) begin
            dz = 1'b1; ov = 1'b0; o = sat;
        end else begin
            dz = 1'b0;
            qv = (ma << Q) / mb;
            if (qv > 64'h0000_0000_7FFF_FFFF) begin
                ov = 1'b1; o = sat;
            end else begin
                ov = 1'b0;
                o  = neg ? 32'(64'd0 - qv) : 32'(qv);
            end
        end
    endfunction

    // ---------------- transaction-level model ----------------
    // Tracks accept / fixed latency / held result at the transaction level.
    logic        m_busy, m_done, m_dz, m_ov;
    logic [31:0] m_out;
    logic [31:0] p_out;
    logic        p_dz, p_ov;
    int          m_age;

    initial begin
        m_busy = 0; m_done = 0; m_dz = 0; m_ov = 0; m_out = '0; m_age = 0;
        p_out = '0; p_dz = 0; p_ov = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_dz = 0; m_ov = 0; m_out = '0; m_age = 0;
            end else if (m_busy) begin
                m_age++;
                if (m_age == LAT) begin
                    m_busy = 0;
                    m_done = 1;
                    m_out  = p_out;
                    m_dz   = p_dz;
                    m_ov   = p_ov;
                end
            end else begin
                m_done = 0;
                if (bus.start === 1'b1) begin
                    m_busy = 1;
                    m_age  = 0;
                    ref_div(bus.in_1, bus.in_2, p_out, p_dz, p_ov);
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_busy", 32'(bus.busy), 32'(m_busy));
            check("cmp_done", 32'(bus.done), 32'(m_done));
            check("cmp_out",  bus.out, m_out);
            check("cmp_dz",   32'(bus.div_by_zero), 32'(m_dz));
            check("cmp_ov",   32'(bus.overflow), 32'(m_ov));
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the divider idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit chk,
                          input logic [31:0] e_out, input logic e_dz, input logic e_ov,
                          input string name);
        int edges;
        bit busy_ok;
        bit seen;
        bus.in_1  = a;
        bus.in_2  = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_ok = (bus.busy === 1'b1);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) seen = 1;
            else if (bus.busy !== 1'b1) busy_ok = 0;
        end
        check({name, "_latency"}, 32'(edges), 32'(LAT));
        check({name, "_busy"}, 32'(busy_ok), 32'd1);
        if (chk) begin
            check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            check({name, "_out"}, bus.out, e_out);
            check({name, "_dz"},  32'(bus.div_by_zero), 32'(e_dz));
            check({name, "_ov"},  32'(bus.overflow), 32'(e_ov));
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0, 1:    v = $urandom;
            2:       v = $urandom_range(0, 32'h000F_FFFF);
            3:       v = 32'd0 - 32'($urandom_range(0, 32'h000F_FFFF));
            4:       v = 32'h8000_0000;
            default: v = 32'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] o;
        logic        dz, ov;
        int          edges, cnt, done_cnt;
        int          d_idx[3];
        bit          seen;

        bus.start = 1'b0;
        bus.in_1  = '0;
        bus.in_2  = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n  = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_out",  bus.out, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz",   32'(bus.div_by_zero), 32'd0);
        check("rst_ov",   32'(bus.overflow), 32'd0);

        // Pin the reference arithmetic to hand-computed values.
        ref_div(32'h0000_6000, 32'h0000_2000, o, dz, ov);
        check("pin_basic", o, 32'h0000_3000);
        ref_div(32'hFFFF_F000, 32'h0000_3000, o, dz, ov);
        check("pin_trunc_neg", o, 32'hFFFF_FAAB);
        ref_div(32'hC000_0000, 32'h0000_0001, o, dz, ov);
        check("pin_sat_neg", o, 32'h8000_0001);
        check("pin_sat_neg_ov", 32'(ov), 32'd1);
        ref_div(32'hFFFF_F000, 32'h0000_0000, o, dz, ov);
        check("pin_dz", 32'(dz), 32'd1);

        vecs.push_back('{32'h0000_6000, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_8800, 32'h0000_2000, 32'hFFFF_C400, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_1000, 32'h0000_3000, 32'h0000_0555, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_F000, 32'h0000_3000, 32'hFFFF_FAAB, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{32'hC000_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFF_F000, 32'h0000_0000, 32'h8000_0001, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_1000, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_1000, 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0});
        vecs.push_back('{32'h0007_FFFF, 32'h0000_0001, 32'h7FFF_F000, 1'b0, 1'b0});
        vecs.push_back('{32'h0008_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{32'hFFF8_0000, 32'h0000_0001, 32'h8000_0001, 1'b0, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 1'b1, vecs[i].o, vecs[i].dz, vecs[i].ov,
                   $sformatf("vec%0d", i));
        end

        // Result holds while idle.
        repeat (10) @(posedge clk);
        #1;
        check("hold_out", bus.out, 32'h7FFF_FFFF);
        check("hold_dz",  32'(bus.div_by_zero), 32'd1);

        // start held high: one done every LAT+1 cycles.
        bus.in_1  = 32'h0000_6000;
        bus.in_2  = 32'h0000_2000;
        bus.start = 1'b1;
        cnt = 0; edges = 0;
        d_idx[0] = 0; d_idx[1] = 0; d_idx[2] = 0;
        while (cnt < 3 && edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) begin
                d_idx[cnt] = edges;
                cnt++;
            end
        end
        bus.start = 1'b0;
        check("cont_count", 32'(cnt), 32'd3);
        check("cont_first", 32'(d_idx[0]), 32'(LAT + 1));
        check("cont_gap1",  32'(d_idx[1] - d_idx[0]), 32'(LAT + 1));
        check("cont_gap2",  32'(d_idx[2] - d_idx[1]), 32'(LAT + 1));
        check("cont_out",   bus.out, 32'h0000_3000);

        // Operands and start churn while busy must not disturb the result.
        bus.in_1  = 32'h0000_1000;
        bus.in_2  = 32'h0000_3000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 0; seen = 0;
        while (!seen && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) begin
                seen = 1;
                bus.start = 1'b0;
            end else begin
                bus.start = edges[0];
                bus.in_1  = $urandom;
                bus.in_2  = $urandom;
            end
        end
        check("tog_latency", 32'(edges), 32'(LAT));
        check("tog_out", bus.out, 32'h0000_0555);

        // Reset in the middle of an operation.
        run_op(32'hFFFF_F000, 32'h0000_0000, 1'b1, 32'h8000_0001, 1'b1, 1'b0, "dz_pre_rst");
        bus.in_1  = 32'h0000_6000;
        bus.in_2  = 32'h0000_2000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (21) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_out",  bus.out, 32'h0);
        check("midrst_dz",   32'(bus.div_by_zero), 32'd0);
        check("midrst_ov",   32'(bus.overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        done_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        run_op(32'h0000_1000, 32'h0000_1000, 1'b1, 32'h0000_1000, 1'b0, 1'b0, "post_rst");

        // Randomised operands, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            run_op(rand_operand(), rand_operand(), 1'b0, 32'h0, 1'b0, 1'b0, "rand");
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
